// File: rtl/vram_pkg.sv
// Shared slot-owner type, default widths and the slot-owner decode for the VRAM arbiter.
package vram_pkg;

  localparam int unsigned VRAM_ADDR_WIDTH = 17;
  localparam int unsigned VRAM_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    SLOT_NONE  = 2'd0,
    SLOT_VIDEO = 2'd1,
    SLOT_CPU   = 2'd2
  } slot_owner_e;

  // Even slots belong to video unless blanking lets a CPU access in; odd slots serve the CPU only.
  function automatic slot_owner_e decode_owner(
    input logic phase,
    input logic vblank,
    input logic cpu_ok
  );
    if (!phase) begin
      return (vblank && cpu_ok) ? SLOT_CPU : SLOT_VIDEO;
    end
    return cpu_ok ? SLOT_CPU : SLOT_NONE;
  endfunction

endpackage

// File: rtl/vram_arbiter.sv
// Single-port SRAM arbiter: time-slices VRAM between video scan-out and CPU accesses.
// Each clock is one slot; all SRAM-facing and handshake outputs are registered.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = VRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = VRAM_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic [ADDR_WIDTH-1:0] videoAddress,
  input  logic                  vBlank,
  output logic [DATA_WIDTH-1:0] videoData,
  output logic                  videoDataReady,
  input  logic                  cpuReq,
  input  logic                  cpuWrite,
  input  logic [ADDR_WIDTH-1:0] cpuAddress,
  input  logic [DATA_WIDTH-1:0] cpuWriteData,
  output logic [DATA_WIDTH-1:0] cpuReadData,
  output logic                  cpuAck,
  output logic [ADDR_WIDTH-1:0] sramAddress,
  input  logic [DATA_WIDTH-1:0] sramDataIn,
  output logic [DATA_WIDTH-1:0] sramDataOut,
  output logic                  sramDataOe,
  output logic                  sramOeN,
  output logic                  sramWeN
);

  logic            slot_phase;
  logic            slot_phase_d;
  slot_owner_e     owner_q;
  slot_owner_e     owner_d;
  logic            write_q;
  logic            write_d;
  logic            in_progress_q;
  logic            in_progress_d;
  logic            cpu_ok;

  logic [ADDR_WIDTH-1:0] sram_address_d;
  logic [DATA_WIDTH-1:0] sram_data_out_d;
  logic                  sram_data_oe_d;
  logic                  sram_oe_n_d;
  logic                  sram_we_n_d;
  logic [DATA_WIDTH-1:0] video_data_d;
  logic                  video_data_ready_d;
  logic [DATA_WIDTH-1:0] cpu_read_data_d;
  logic                  cpu_ack_d;

  // Next-slot decision and next register values.
  always_comb begin
    slot_phase_d       = ~slot_phase;
    cpu_ok             = cpuReq & ~in_progress_q;
    owner_d            = decode_owner(slot_phase, vBlank, cpu_ok);
    write_d            = cpuWrite & (owner_d == SLOT_CPU);
    in_progress_d      = (owner_d == SLOT_CPU);

    sram_address_d     = sramAddress;
    sram_data_out_d    = sramDataOut;
    sram_data_oe_d     = 1'b0;
    sram_oe_n_d        = 1'b1;
    sram_we_n_d        = 1'b1;
    video_data_d       = videoData;
    video_data_ready_d = 1'b0;
    cpu_read_data_d    = cpuReadData;
    cpu_ack_d          = 1'b0;

    // Set up the SRAM cycle for the slot starting at this edge.
    case (owner_d)
      SLOT_VIDEO: begin
        sram_address_d = videoAddress;
        sram_oe_n_d    = 1'b0;
      end
      SLOT_CPU: begin
        sram_address_d = cpuAddress;
        if (cpuWrite) begin
          sram_we_n_d     = 1'b0;
          sram_data_oe_d  = 1'b1;
          sram_data_out_d = cpuWriteData;
        end else begin
          sram_oe_n_d     = 1'b0;
        end
      end
      default: ;
    endcase

    // Retire the slot ending at this edge.
    case (owner_q)
      SLOT_VIDEO: begin
        video_data_d       = sramDataIn;
        video_data_ready_d = 1'b1;
      end
      SLOT_CPU: begin
        cpu_ack_d = 1'b1;
        if (!write_q) begin
          cpu_read_data_d = sramDataIn;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      slot_phase     <= 1'b0;
      owner_q        <= SLOT_NONE;
      write_q        <= 1'b0;
      in_progress_q  <= 1'b0;
      sramAddress    <= '0;
      sramDataOut    <= '0;
      sramDataOe     <= 1'b0;
      sramOeN        <= 1'b1;
      sramWeN        <= 1'b1;
      videoData      <= '0;
      videoDataReady <= 1'b0;
      cpuReadData    <= '0;
      cpuAck         <= 1'b0;
    end else begin
      slot_phase     <= slot_phase_d;
      owner_q        <= owner_d;
      write_q        <= write_d;
      in_progress_q  <= in_progress_d;
      sramAddress    <= sram_address_d;
      sramDataOut    <= sram_data_out_d;
      sramDataOe     <= sram_data_oe_d;
      sramOeN        <= sram_oe_n_d;
      sramWeN        <= sram_we_n_d;
      videoData      <= video_data_d;
      videoDataReady <= video_data_ready_d;
      cpuReadData    <= cpu_read_data_d;
      cpuAck         <= cpu_ack_d;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a slot-level reference model queues expectations,
// a negedge monitor checks every SRAM cycle and every data/ack pulse.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 8;
  localparam int unsigned BW = AW + DW + 3;

  logic          clk;
  logic          resetN;
  logic [AW-1:0] videoAddress;
  logic          vBlank;
  logic [DW-1:0] videoData;
  logic          videoDataReady;
  logic          cpuReq;
  logic          cpuWrite;
  logic [AW-1:0] cpuAddress;
  logic [DW-1:0] cpuWriteData;
  logic [DW-1:0] cpuReadData;
  logic          cpuAck;
  logic [AW-1:0] sramAddress;
  logic [DW-1:0] sramDataIn;
  logic [DW-1:0] sramDataOut;
  logic          sramDataOe;
  logic          sramOeN;
  logic          sramWeN;

  int total = 0;
  int bad   = 0;

  vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock         (clk),
    .resetN        (resetN),
    .videoAddress  (videoAddress),
    .vBlank        (vBlank),
    .videoData     (videoData),
    .videoDataReady(videoDataReady),
    .cpuReq        (cpuReq),
    .cpuWrite      (cpuWrite),
    .cpuAddress    (cpuAddress),
    .cpuWriteData  (cpuWriteData),
    .cpuReadData   (cpuReadData),
    .cpuAck        (cpuAck),
    .sramAddress   (sramAddress),
    .sramDataIn    (sramDataIn),
    .sramDataOut   (sramDataOut),
    .sramDataOe    (sramDataOe),
    .sramOeN       (sramOeN),
    .sramWeN       (sramWeN)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } byte_exp_t;

  byte_exp_t        video_q[$];
  byte_exp_t        cpu_q[$];
  logic [BW-1:0]    sram_q[$];

  // Reference model state (slot rules expressed directly in edge counts)
  int               edge_cnt;
  int               cpu_free;
  slot_owner_e      prev_owner;
  logic             prev_write;
  slot_owner_e      own;
  logic             ok;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_dout;
  logic [DW-1:0]    m_rd;

  initial begin
    edge_cnt = 0;
    forever begin
      @(posedge clk);
      if (!resetN) begin
        edge_cnt   = 0;
        cpu_free   = 0;
        prev_owner = SLOT_NONE;
        prev_write = 1'b0;
        m_addr     = '0;
        m_dout     = '0;
        m_rd       = '0;
        video_q.delete();
        cpu_q.delete();
        sram_q.delete();
      end else begin
        ok = cpuReq && (edge_cnt >= cpu_free);
        if (edge_cnt % 2 == 0) own = (vBlank && ok) ? SLOT_CPU : SLOT_VIDEO;
        else                   own = ok ? SLOT_CPU : SLOT_NONE;
        if (prev_owner == SLOT_VIDEO) video_q.push_back('{edge_cnt + 1, sramDataIn});
        if (prev_owner == SLOT_CPU) begin
          if (!prev_write) m_rd = sramDataIn;
          cpu_q.push_back('{edge_cnt + 1, m_rd});
        end
        if (own == SLOT_VIDEO) begin
          m_addr = videoAddress;
          sram_q.push_back({m_addr, 1'b0, 1'b1, 1'b0, m_dout});
        end else if (own == SLOT_CPU) begin
          m_addr   = cpuAddress;
          cpu_free = edge_cnt + 2;
          if (cpuWrite) begin
            m_dout = cpuWriteData;
            sram_q.push_back({m_addr, 1'b1, 1'b0, 1'b1, m_dout});
          end else begin
            sram_q.push_back({m_addr, 1'b0, 1'b1, 1'b0, m_dout});
          end
        end else begin
          sram_q.push_back({m_addr, 1'b1, 1'b1, 1'b0, m_dout});
        end
        prev_owner = own;
        prev_write = cpuWrite;
        edge_cnt++;
      end
    end
  end

  // Monitor: compares DUT outputs against queued expectations every negedge.
  logic [BW-1:0] mon_bus;
  byte_exp_t     mon_item;
  logic          exp_v;
  logic          exp_c;

  initial begin
    forever begin
      @(negedge clk);
      if (!resetN) begin
        check("reset_outputs",
              64'({sramAddress, sramOeN, sramWeN, sramDataOe, sramDataOut,
                   videoData, videoDataReady, cpuReadData, cpuAck}),
              64'({AW'(0), 1'b1, 1'b1, 1'b0, DW'(0), DW'(0), 1'b0, DW'(0), 1'b0}));
      end else if (edge_cnt > 0) begin
        if (sram_q.size() > 0) begin
          mon_bus = sram_q.pop_front();
          check("sram_cycle", 64'({sramAddress, sramOeN, sramWeN, sramDataOe, sramDataOut}),
                64'(mon_bus));
        end
        check("we_oe_overlap", 64'(!sramWeN && !sramOeN), 64'(0));

        exp_v = (video_q.size() > 0) && (video_q[0].due == edge_cnt);
        check("video_ready", 64'(videoDataReady), 64'(exp_v));
        if (exp_v) begin
          mon_item = video_q.pop_front();
          if (videoDataReady) check("video_data", 64'(videoData), 64'(mon_item.data));
        end

        exp_c = (cpu_q.size() > 0) && (cpu_q[0].due == edge_cnt);
        check("cpu_ack", 64'(cpuAck), 64'(exp_c));
        if (exp_c) begin
          mon_item = cpu_q.pop_front();
          if (cpuAck) check("cpu_read_data", 64'(cpuReadData), 64'(mon_item.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpuReq       = 1'b0;
    cpuWrite     = 1'b0;
    cpuAddress   = '0;
    cpuWriteData = '0;
    vBlank       = 1'b0;
    videoAddress = '0;
    sramDataIn   = '0;
  endtask

  task automatic enter_reset();
    resetN = 1'b0;
    repeat (3) tick();
    idle_inputs();
  endtask

  logic [8:0] ack_mask;
  logic       stale;

  initial begin
    idle_inputs();
    resetN = 1'b1;
    #1 resetN = 1'b0;
    repeat (3) tick();
    check("reset_oe_we", 64'({sramOeN, sramWeN, cpuAck}), 64'(3'b110));

    // Video-only fetch
    videoAddress = 17'h00123;
    sramDataIn   = 8'h5A;
    resetN       = 1'b1;
    tick();
    check("vid_addr", 64'({sramAddress, sramOeN}), 64'({17'h00123, 1'b0}));
    tick();
    check("vid_data", 64'({videoData, videoDataReady}), 64'({8'h5A, 1'b1}));
    tick();
    check("vid_pulse_one", 64'(videoDataReady), 64'(0));

    // CPU write during active video lands in the phase-1 slot
    enter_reset();
    videoAddress = 17'h00040;
    cpuReq       = 1'b1;
    cpuWrite     = 1'b1;
    cpuAddress   = 17'h1FFFF;
    cpuWriteData = 8'hA5;
    resetN       = 1'b1;
    tick();
    check("wr_video_first", 64'({sramAddress, sramOeN}), 64'({17'h00040, 1'b0}));
    tick();
    check("wr_slot", 64'({sramAddress, sramWeN, sramOeN, sramDataOe, sramDataOut}),
          64'({17'h1FFFF, 1'b0, 1'b1, 1'b1, 8'hA5}));
    cpuReq = 1'b0;
    tick();
    check("wr_ack", 64'({cpuAck, sramAddress, sramOeN}), 64'({1'b1, 17'h00040, 1'b0}));
    tick();
    check("wr_ack_one", 64'(cpuAck), 64'(0));

    // CPU read in blanking takes the phase-0 slot
    enter_reset();
    vBlank       = 1'b1;
    cpuReq       = 1'b1;
    cpuAddress   = 17'h0ABCD;
    sramDataIn   = 8'h3C;
    videoAddress = 17'h00777;
    resetN       = 1'b1;
    tick();
    check("rd_slot", 64'({sramAddress, sramOeN, sramWeN, sramDataOe}),
          64'({17'h0ABCD, 1'b0, 1'b1, 1'b0}));
    cpuReq = 1'b0;
    tick();
    check("rd_ack", 64'({cpuAck, cpuReadData, videoDataReady}), 64'({1'b1, 8'h3C, 1'b0}));

    // Back-to-back CPU requests in blanking
    enter_reset();
    vBlank     = 1'b1;
    cpuReq     = 1'b1;
    cpuAddress = 17'h00010;
    resetN     = 1'b1;
    ack_mask   = '0;
    for (int i = 0; i < 9; i++) begin
      tick();
      ack_mask[i] = cpuAck;
      sramDataIn  = DW'($urandom);
      if (i == 5) cpuReq = 1'b0;
    end
    check("b2b_ack_pattern", 64'(ack_mask), 64'(9'b000101010));

    // Reset in the middle of a CPU write
    enter_reset();
    cpuReq       = 1'b1;
    cpuWrite     = 1'b1;
    cpuAddress   = 17'h01234;
    cpuWriteData = 8'h99;
    resetN       = 1'b1;
    tick();
    tick();
    check("rst_pre_we", 64'(sramWeN), 64'(0));
    resetN = 1'b0;
    #1;
    check("rst_abort", 64'({sramWeN, cpuAck}), 64'(2'b10));
    cpuReq = 1'b0;
    repeat (2) tick();
    resetN = 1'b1;
    stale  = 1'b0;
    repeat (6) begin
      tick();
      stale = stale | cpuAck;
    end
    check("rst_stale_ack", 64'(stale), 64'(0));

    // Randomized traffic
    enter_reset();
    resetN = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      tick();
      cpuReq       = ($urandom_range(9) < 6);
      cpuWrite     = 1'($urandom_range(1));
      cpuAddress   = AW'($urandom);
      cpuWriteData = DW'($urandom);
      videoAddress = AW'($urandom);
      sramDataIn   = DW'($urandom);
      if ($urandom_range(15) == 0) vBlank = ~vBlank;
      if ($urandom_range(499) == 0) begin
        resetN = 1'b0;
        repeat (2) tick();
        resetN = 1'b1;
      end
    end
    cpuReq = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    #1;
    check("leftover_expectations", 64'(video_q.size() + cpu_q.size() + sram_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 17, the VRAM byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the VRAM data width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
- clock  in  1  system clock; the video pixel rate is clock/2.
- resetN  in  1  asynchronous active-low reset.
- videoAddress  in  ADDR_WIDTH  current scan-out fetch address.
- vBlank  in  1  high during vertical blanking.
- videoData  out  DATA_WIDTH  last byte fetched for video.
- videoDataReady  out  1  one-cycle pulse: videoData was updated.
- cpuReq  in  1  CPU access request, held until cpuAck.
- cpuWrite  in  1  1 = write, 0 = read; qualified by cpuReq.
- cpuAddress  in  ADDR_WIDTH  CPU access address.
- cpuWriteData  in  DATA_WIDTH  CPU write byte.
- cpuReadData  out  DATA_WIDTH  last byte read by the CPU.
- cpuAck  out  1  one-cycle pulse: CPU access completed.
- sramAddress  out  ADDR_WIDTH  SRAM address, registered.
- sramDataIn  in  DATA_WIDTH  SRAM read data.
- sramDataOut  out  DATA_WIDTH  SRAM write data, registered.
- sramDataOe  out  1  1 = drive sramDataOut onto the bus (tristate is at the top level).
- sramOeN  out  1  SRAM output enable, active low.
- sramWeN  out  1  SRAM write enable, active low.

Function
REQ-004 SHALL keep a 1-bit slotPhase register that toggles on every clock and leaves reset at 0; each clock cycle is one slot.
REQ-005 SHALL assign the owner of a slot at the rising edge that starts it, using inputs sampled at that edge:
- phase 0: VIDEO, unless vBlank=1 and a CPU request is acceptable, in which case CPU.
- phase 1: CPU if a CPU request is acceptable, otherwise NONE.
REQ-006 A CPU request SHALL be acceptable when cpuReq=1 and no CPU access is in progress; "in progress" covers the CPU slot itself and the following cycle in which cpuAck is high.
REQ-007 At the start of a VIDEO slot, the block SHALL register sramAddress=videoAddress, sramOeN=0, sramWeN=1 and sramDataOe=0.
REQ-008 At the edge ending a VIDEO slot, the block SHALL capture sramDataIn into videoData and set videoDataReady=1 for exactly one cycle, giving 2-edge latency from videoAddress sample to videoDataReady.
REQ-009 At the start of a CPU slot, the block SHALL register sramAddress=cpuAddress.
- Read: sramOeN=0, sramWeN=1, sramDataOe=0.
- Write: sramOeN=1, sramWeN=0, sramDataOe=1, sramDataOut=cpuWriteData.
REQ-010 At the edge ending a CPU slot, the block SHALL set cpuAck=1 for exactly one cycle, and for a read SHALL also capture sramDataIn into cpuReadData.
REQ-011 cpuReadData SHALL hold its value until the next CPU read completes; writes SHALL NOT alter it.
REQ-012 cpuReq sampled high at the edge that raises cpuAck SHALL be ignored; cpuReq sampled high while cpuAck=1 SHALL be treated as a new request. The CPU throughput limit is therefore one access per 2 cycles.
REQ-013 A NONE slot SHALL drive sramOeN=1, sramWeN=1 and sramDataOe=0; sramAddress SHALL hold its previous value.
REQ-014 The block SHALL never grant video and CPU in the same slot, and sramWeN=0 SHALL never coincide with sramOeN=0.
REQ-015 While vBlank=0, a CPU request SHALL be granted within 2 cycles of first becoming acceptable.
REQ-016 When vBlank deasserts, the next phase-0 slot SHALL be VIDEO, with no extra delay.

Reset
REQ-017 While resetN=0, the block SHALL hold:
- slotPhase=0, sramAddress=0, sramDataOut=0, sramDataOe=0, sramOeN=1, sramWeN=1;
- videoData=0, videoDataReady=0, cpuReadData=0, cpuAck=0;
- in-progress flag cleared.
REQ-018 Reset asserted mid-access SHALL abort that access with no cpuAck or videoDataReady; after release, the first slot is phase 0.

Structure
REQ-019 Package vram_pkg SHALL hold the slot_owner_e enum (SLOT_NONE, SLOT_VIDEO, SLOT_CPU) and the default ADDR_WIDTH/DATA_WIDTH constants.
REQ-020 vram_arbiter SHALL be a single module with no sub-modules; the owner decode SHALL be combinational and every SRAM-facing output registered.

Verification
REQ-021 Video only: after reset, videoAddress=0x00123 and SRAM returns 0x5A -> sramAddress=0x00123 with sramOeN=0 in the phase-0 slot; next cycle videoData=0x5A and videoDataReady=1 for one cycle.
REQ-022 CPU write during active video: cpuReq=1, cpuWrite=1, cpuAddress=0x1FFFF, cpuWriteData=0xA5 raised in a phase-0 cycle -> the phase-1 slot shows sramWeN=0, sramDataOe=1, sramDataOut=0xA5; cpuAck=1 the next cycle; video slots are unaffected.
REQ-023 CPU read during vBlank=1: cpuReq raised with phase=0 next -> the phase-0 slot goes to CPU; cpuReadData equals the SRAM byte and cpuAck pulses 1 cycle later; no videoDataReady in that slot.
REQ-024 Back-to-back CPU: cpuReq held high for 6 cycles with vBlank=1 -> exactly 3 cpuAck pulses, each 2 cycles apart.
REQ-025 Reset mid-write: resetN=0 during a CPU write slot -> sramWeN=1 and cpuAck=0 immediately; after release, no stale ack appears.
